// File: rtl/uart_cmd_slave.sv
// uart_cmd_slave
//   UART command slave. Receives a two-byte command {byte1, byte0} on rx
//   (byte0 first), performs a one-cycle register write or read strobe, and
//   for reads transmits the captured register byte back on tx after a fixed
//   turnaround delay. The link is half-duplex: rx is ignored while a
//   response is pending or on the wire.
//
//   Configuration macro: UART_PARITY_EN
//     defined   -> 8O1 frames (odd parity generated on tx, checked on rx)
//     undefined -> 8N1 frames (RX_PAR/TX_PAR never entered, no parity errors)
//
//   Parameters:
//     BR       clocks per bit period (2..65535)
//     RSP_DLY  clocks spent in RSP_WAIT before the response start bit (>= 1)
//     TMO_BITS inter-byte timeout in bit periods
module uart_cmd_slave #(
  parameter int BR       = 434,
  parameter int RSP_DLY  = 100,
  parameter int TMO_BITS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic       reg_wr,
  output logic       reg_rd,
  output logic [6:0] reg_addr,
  output logic [7:0] reg_wdata,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE,
    RX_START,
    RX_DATA,
    RX_PAR,
    RX_STOP,
    BYTE_GAP,
    EXEC_WR,
    EXEC_RD,
    RD_CAP,
    RSP_WAIT,
    TX_START,
    TX_DATA,
    TX_PAR,
    TX_STOP
  } state_t;

  // Bit timing uses a 16-bit counter so BR up to 65535 never wraps before
  // its terminal count; the timeout and turnaround counters are 32 bits.
  localparam logic [15:0] BIT_LAST = 16'(BR - 1);
  localparam logic [15:0] BIT_HALF = 16'(BR / 2);
  localparam logic [31:0] TMO_LAST = 32'(TMO_BITS * BR - 1);
  localparam logic [31:0] RSP_LAST = 32'(RSP_DLY - 1);

  state_t      state;
  logic [15:0] bit_cnt;
  logic [2:0]  bit_idx;
  logic [31:0] tmo_cnt;
  logic [31:0] rsp_cnt;
  logic [7:0]  rx_shreg;
  logic [7:0]  byte0;
  logic        byte_sel;   // 0: receiving byte0, 1: receiving byte1
  logic [7:0]  tx_shreg;
  logic        rx_meta;
  logic        rx_sync;
  logic        rx_sync_d;
  logic        start_edge;
  logic        parity_ok;

`ifdef UART_PARITY_EN
  logic        rx_par;
  logic        tx_par;

  // Odd parity: data ones plus the parity bit must be odd.
  assign parity_ok = ^{rx_shreg, rx_par};
`else
  assign parity_ok = 1'b1;
`endif

  assign start_edge = rx_sync_d & ~rx_sync;

  // Two-flop synchroniser for the asynchronous rx line, plus an edge-detect stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sync flops reset to the idle line level (1) so that leaving
      // reset never fabricates a start edge.
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_sync_d <= 1'b1;
    end else begin
      rx_meta   <= rx;
      rx_sync   <= rx_meta;
      rx_sync_d <= rx_sync;
    end
  end

  // Command FSM: receive two bytes, execute the strobe, transmit read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      tmo_cnt   <= '0;
      rsp_cnt   <= '0;
      rx_shreg  <= '0;
      byte0     <= '0;
      byte_sel  <= 1'b0;
      tx_shreg  <= '0;
      tx        <= 1'b1;
      reg_wr    <= 1'b0;
      reg_rd    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par    <= 1'b0;
      tx_par    <= 1'b0;
`endif
    end else begin
      // NOTE: pulse outputs default low here so each state only sets them
      // for the single cycle it needs; every assignment is non-blocking.
      err    <= 1'b0;
      reg_wr <= 1'b0;
      reg_rd <= 1'b0;

      case (state)
        IDLE: begin
          byte_sel <= 1'b0;
          if (start_edge) begin
            bit_cnt <= '0;
            state   <= RX_START;
          end
        end

        RX_START: begin
          if (bit_cnt == BIT_HALF) begin
            bit_cnt <= '0;
            if (rx_sync) begin
              // Start glitch: drop silently and resume waiting.
              state <= byte_sel ? BYTE_GAP : IDLE;
            end else begin
              bit_idx <= '0;
              busy    <= 1'b1;
              state   <= RX_DATA;
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        RX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            rx_shreg <= {rx_sync, rx_shreg[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              state <= RX_PAR;
`else
              state <= RX_STOP;
`endif
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

`ifdef UART_PARITY_EN
        RX_PAR: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            rx_par  <= rx_sync;
            state   <= RX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
`endif

        RX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            if (!rx_sync || !parity_ok) begin
              // Framing or parity error discards the whole command.
              err      <= 1'b1;
              busy     <= 1'b0;
              byte_sel <= 1'b0;
              state    <= IDLE;
            end else if (!byte_sel) begin
              byte0    <= rx_shreg;
              byte_sel <= 1'b1;
              tmo_cnt  <= '0;
              state    <= BYTE_GAP;
            end else begin
              // Decode cmd = {byte1, byte0}; address and data then stay
              // put until the next decode.
              byte_sel <= 1'b0;
              reg_addr <= rx_shreg[6:0];
              if (rx_shreg[7]) begin
                reg_wdata <= byte0;
                reg_wr    <= 1'b1;
                state     <= EXEC_WR;
              end else begin
                reg_rd <= 1'b1;
                state  <= EXEC_RD;
              end
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        BYTE_GAP: begin
          if (start_edge) begin
            bit_cnt <= '0;
            state   <= RX_START;
          end else if (tmo_cnt == TMO_LAST) begin
            // Inter-byte timeout: byte0 is dropped without an error.
            busy     <= 1'b0;
            byte_sel <= 1'b0;
            state    <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end

        EXEC_WR: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        EXEC_RD: begin
          state <= RD_CAP;
        end

        RD_CAP: begin
          // Register file answers the strobe one clock later.
          tx_shreg <= reg_rdata;
`ifdef UART_PARITY_EN
          tx_par   <= ~^reg_rdata;
`endif
          rsp_cnt  <= '0;
          state    <= RSP_WAIT;
        end

        RSP_WAIT: begin
          if (rsp_cnt == RSP_LAST) begin
            tx      <= 1'b0;
            bit_cnt <= '0;
            state   <= TX_START;
          end else begin
            rsp_cnt <= rsp_cnt + 32'd1;
          end
        end

        TX_START: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt  <= '0;
            bit_idx  <= '0;
            tx       <= tx_shreg[0];
            tx_shreg <= {1'b0, tx_shreg[7:1]};
            state    <= TX_DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        TX_DATA: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              tx    <= tx_par;
              state <= TX_PAR;
`else
              tx    <= 1'b1;
              state <= TX_STOP;
`endif
            end else begin
              tx       <= tx_shreg[0];
              tx_shreg <= {1'b0, tx_shreg[7:1]};
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

`ifdef UART_PARITY_EN
        TX_PAR: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= TX_STOP;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
`endif

        TX_STOP: begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
